turn_sequencer: RTL and testbench

Game-flow controller that generates the 3-bit `state` word consumed by the p1handed/p2handed decoders. It hands control alternately to player 1 and player 2 and inserts a fixed handoff gap between turns. It enforces a per-turn timeout, counts accepted moves, and terminates in win, forfeit or draw. It sits between the player input synchronisers and all state-decoding and display logic.

---
 rtl/turn_sequencer.sv | 126 ++++++++++++
 tb/tb_turn_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Two-player turn sequencer: alternates P1/P2 turns with a fixed handoff gap,
// enforces a per-turn timeout, counts accepted moves and ends in win/forfeit/draw.
module turn_sequencer #(
  parameter int TURN_TIMEOUT   = 8,
  parameter int HANDOFF_CYCLES = 2,
  parameter int MAX_TURNS      = 4,
  parameter int TIMER_W        = 8,
  parameter int TURN_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               p1_move,
  input  logic               p2_move,
  input  logic               win,
  output logic [2:0]         state,
  output logic [TURN_W-1:0]  turn_cnt,
  output logic [TIMER_W-1:0] timer,
  output logic               illegal
);

  // Encoding is consumed by downstream p1handed/p2handed decoders; do not reorder.
  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_P1     = 3'b001;
  localparam logic [2:0] S_H2P2   = 3'b010;
  localparam logic [2:0] S_P2     = 3'b011;
  localparam logic [2:0] S_H2P1   = 3'b100;
  localparam logic [2:0] S_P1_WIN = 3'b101;
  localparam logic [2:0] S_P2_WIN = 3'b110;
  localparam logic [2:0] S_DRAW   = 3'b111;

  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HAND_LOAD = TIMER_W'(HANDOFF_CYCLES - 1);
  localparam logic [TURN_W-1:0]  MAX_CNT   = TURN_W'(MAX_TURNS);

  logic [2:0]         state_q, state_d;
  logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               illegal_q, illegal_d;
  logic [TURN_W-1:0]  turn_inc;
  logic               timer_zero;

  assign turn_inc   = turn_cnt_q + TURN_W'(1);
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    timer_d    = timer_q;
    illegal_d  = 1'b0;
    case (state_q)
      S_P1: begin
        illegal_d = p2_move;
        // An accepted move beats a same-cycle timeout.
        if (p1_move) begin
          turn_cnt_d = turn_inc;
          timer_d    = '0;
          if (win)                    state_d = S_P1_WIN;
          else if (turn_inc == MAX_CNT) state_d = S_DRAW;
          else begin
            state_d = S_H2P2;
            timer_d = HAND_LOAD;
          end
        end else if (timer_zero) begin
          state_d = S_P2_WIN;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_P2: begin
        illegal_d = p1_move;
        if (p2_move) begin
          turn_cnt_d = turn_inc;
          timer_d    = '0;
          if (win)                    state_d = S_P2_WIN;
          else if (turn_inc == MAX_CNT) state_d = S_DRAW;
          else begin
            state_d = S_H2P1;
            timer_d = HAND_LOAD;
          end
        end else if (timer_zero) begin
          state_d = S_P1_WIN;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_H2P2, S_H2P1: begin
        illegal_d = p1_move | p2_move;
        if (timer_zero) begin
          state_d = (state_q == S_H2P2) ? S_P2 : S_P1;
          timer_d = TURN_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        // IDLE and terminal states: only start matters.
        if (start) begin
          state_d    = S_P1;
          turn_cnt_d = '0;
          timer_d    = TURN_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      turn_cnt_q <= '0;
      timer_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      timer_q    <= timer_d;
      illegal_q  <= illegal_d;
    end
  end

  assign state    = state_q;
  assign turn_cnt = turn_cnt_q;
  assign timer    = timer_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with default parameters (timeout 8, handoff 2, draw at 4).
module tb_turn_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, p1_move, p2_move, win;
  logic [2:0] state;
  logic [7:0] turn_cnt;
  logic [7:0] timer;
  logic       illegal;
  int checks = 0;
  int failures = 0;

  turn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .p1_move(p1_move), .p2_move(p2_move),
    .win(win), .state(state), .turn_cnt(turn_cnt), .timer(timer), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s, input logic [7:0] c,
                         input logic [7:0] t, input logic il);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".cnt"}, 32'(turn_cnt), 32'(c));
    chk({tag, ".timer"}, 32'(timer), 32'(t));
    chk({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    rst_n = 1'b0; start = 0; p1_move = 0; p2_move = 0; win = 0;
    #12;
    chk_all("reset", 3'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle_hold", 32'(state), 32'd0);

    // Normal alternation
    start = 1; step(); start = 0;
    chk_all("alt_p1", 3'd1, 8'd0, 8'd7, 1'b0);
    step(); chk("alt_t6", 32'(timer), 32'd6);
    step(); chk("alt_t5", 32'(timer), 32'd5);
    p1_move = 1; step(); p1_move = 0;
    chk_all("alt_h2p2", 3'd2, 8'd1, 8'd1, 1'b0);
    step(); chk_all("alt_h2p2b", 3'd2, 8'd1, 8'd0, 1'b0);
    step(); chk_all("alt_p2", 3'd3, 8'd1, 8'd7, 1'b0);
    p2_move = 1; step(); p2_move = 0;
    chk_all("alt_h2p1", 3'd4, 8'd2, 8'd1, 1'b0);
    step(); chk_all("alt_h2p1b", 3'd4, 8'd2, 8'd0, 1'b0);
    step(); chk_all("alt_p1b", 3'd1, 8'd2, 8'd7, 1'b0);

    // Simultaneous moves in P1_TURN: p1 accepted, illegal pulse
    p1_move = 1; p2_move = 1; step(); p1_move = 0; p2_move = 0;
    chk_all("simul", 3'd2, 8'd3, 8'd1, 1'b1);
    step(); chk_all("simul_after", 3'd2, 8'd3, 8'd0, 1'b0);
    step(); chk("draw_p2", 32'(state), 32'd3);
    // Fourth accepted move -> draw
    p2_move = 1; step(); p2_move = 0;
    chk_all("draw", 3'd7, 8'd4, 8'd0, 1'b0);
    p1_move = 1; p2_move = 1; step(); p1_move = 0; p2_move = 0;
    chk_all("draw_hold", 3'd7, 8'd4, 8'd0, 1'b0);

    // Illegal during handoff, then win
    start = 1; step(); start = 0;
    chk_all("win_p1", 3'd1, 8'd0, 8'd7, 1'b0);
    p1_move = 1; step(); p1_move = 0;
    chk("win_h", 32'(state), 32'd2);
    p2_move = 1; step(); p2_move = 0;
    chk_all("ho_illegal", 3'd2, 8'd1, 8'd0, 1'b1);
    step(); chk_all("ho_len", 3'd3, 8'd1, 8'd7, 1'b0);
    p2_move = 1; win = 1; step(); p2_move = 0; win = 0;
    chk("p2win_state", 32'(state), 32'd6);
    chk("p2win_cnt", 32'(turn_cnt), 32'd2);
    step(); chk("p2win_hold", 32'(state), 32'd6);
    start = 1; step(); start = 0;
    chk_all("restart", 3'd1, 8'd0, 8'd7, 1'b0);

    // Timeout in P1_TURN -> P2_WIN
    for (int i = 1; i < 8; i++) begin
      step();
      chk("to_timer", 32'(timer), 32'(7 - i));
      chk("to_state", 32'(state), 32'd1);
    end
    step(); chk_all("forfeit_p1", 3'd6, 8'd0, 8'd0, 1'b0);

    // Move on the last cycle beats the timeout
    start = 1; step(); start = 0;
    for (int i = 0; i < 7; i++) step();
    chk("edge_t0", 32'(timer), 32'd0);
    p1_move = 1; step(); p1_move = 0;
    chk_all("edge_move", 3'd2, 8'd1, 8'd1, 1'b0);

    // Timeout in P2_TURN -> P1_WIN
    step(); step();
    chk("p2to_enter", 32'(state), 32'd3);
    for (int i = 0; i < 7; i++) step();
    chk("p2to_t0", 32'(state), 32'd3);
    step(); chk_all("forfeit_p2", 3'd5, 8'd1, 8'd0, 1'b0);

    // Async reset mid-P2_TURN
    start = 1; step(); start = 0;
    p1_move = 1; step(); p1_move = 0;
    step(); step();
    chk("rst_pre", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 3'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step(); chk_all("post_rst", 3'd0, 8'd0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
